// File: rtl/mc_pkg.sv
// Shared types for the multicycle RV32I-subset core: sequencer states, opcodes, ALU control.
package mc_pkg;

  typedef enum logic [3:0] {
    BOOT, FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP, HALT
  } state_t;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LW    = 7'h03;
  localparam logic [6:0] OP_SW    = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_t;

  // funct3 to ALU control for the register and immediate arithmetic groups
  function automatic alu_op_t f3_to_alu(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? ALU_SUB : ALU_ADD;
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      default: return ALU_SLT;
    endcase
  endfunction

endpackage

// File: rtl/mc_if.sv
// Unified instruction/data memory port with a req/ready handshake.
interface mc_if #(parameter int XLEN = 32);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/mc_regfile.sv
// Architectural register file: two async read ports, one sync write port, x0 hardwired to 0.
module mc_regfile #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);
  localparam int AW = $clog2(NREGS);
  localparam logic [5:0] NR = 6'(NREGS);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk)
    if (we && waddr != 5'd0 && {1'b0, waddr} < NR) regs[waddr[AW-1:0]] <= wdata;

  assign rdata1 = (raddr1 == 5'd0 || {1'b0, raddr1} >= NR) ? '0 : regs[raddr1[AW-1:0]];
  assign rdata2 = (raddr2 == 5'd0 || {1'b0, raddr2} >= NR) ? '0 : regs[raddr2[AW-1:0]];
endmodule

// File: rtl/mc_core.sv
// Multicycle RV32I-subset core: one shared ALU and one memory port under a state sequencer.
module mc_core import mc_pkg::*; #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            srst,
  mc_if.master            bus,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            illegal
);
  localparam logic [5:0] NR = 6'(NREGS);

  state_t state, nxt;
  logic [XLEN-1:0] ir, a, b, imm, tgt, aluout, mdr;
  logic [XLEN-1:0] pc_nxt, pc4, imm_dec, rs1_val, rs2_val;
  logic [XLEN-1:0] alu_a, alu_b, alu_y, exec_val, rf_wdata;
  alu_op_t alu_op;
  logic rf_we, legal, bad_reg, exec_bad, taken, f3_ok;

  logic [6:0] opcode, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];

  logic is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr, is_lui, is_auipc;
  assign is_r     = opcode == OP_R;
  assign is_i     = opcode == OP_I;
  assign is_lw    = opcode == OP_LW;
  assign is_sw    = opcode == OP_SW;
  assign is_br    = opcode == OP_BR;
  assign is_jal   = opcode == OP_JAL;
  assign is_jalr  = opcode == OP_JALR;
  assign is_lui   = opcode == OP_LUI;
  assign is_auipc = opcode == OP_AUIPC;

  assign f3_ok = f3 inside {3'b000, 3'b010, 3'b110, 3'b111};
  assign legal = (is_r && f3_ok && (f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'b000)))
              || (is_i && f3_ok) || ((is_lw || is_sw) && f3 == 3'b010)
              || (is_br && f3[2:1] == 2'b00) || (is_jalr && f3 == 3'b000)
              || is_jal || is_lui || is_auipc;

  // Only register fields the format actually uses are range-checked (matters for RV32E).
  assign bad_reg = (!(is_lui || is_auipc || is_jal) && {1'b0, rs1} >= NR)
                || ((is_r || is_sw || is_br) && {1'b0, rs2} >= NR)
                || (!(is_sw || is_br) && {1'b0, rd} >= NR);

  always_comb begin
    imm_dec = {{(XLEN-12){ir[31]}}, ir[31:20]};
    case (opcode)
      OP_SW:            imm_dec = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
      OP_BR:            imm_dec = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_JAL:           imm_dec = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      OP_LUI, OP_AUIPC: imm_dec = {ir[31:12], 12'b0};
      default: ;
    endcase
  end

  // Shared ALU: branch target in DECODE, execute op in EXEC, compare in BRANCH.
  always_comb begin
    alu_a  = a;
    alu_b  = imm;
    alu_op = ALU_ADD;
    case (state)
      DECODE: begin alu_a = pc; alu_b = imm_dec; end
      EXEC: begin
        if (is_r) begin alu_b = b; alu_op = f3_to_alu(f3, f7[5]); end
        else if (is_i) alu_op = f3_to_alu(f3, 1'b0);
      end
      BRANCH: begin alu_b = b; alu_op = ALU_SUB; end
      default: ;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = alu_a + alu_b;
    endcase
  end

  assign pc4      = pc + XLEN'(4);
  assign exec_val = is_lui ? imm : is_auipc ? tgt : is_jalr ? {alu_y[XLEN-1:1], 1'b0} : alu_y;
  assign exec_bad = ((is_lw || is_sw) && exec_val[1:0] != 2'b00) || (is_jalr && exec_val[1]);
  assign taken    = (alu_y == '0) ^ f3[0];
  // jalr links the return address like jal; its ALUOUT carries the jump target
  assign rf_wdata = (state == JUMP || is_jalr) ? pc4 : is_lw ? mdr : aluout;

  mc_regfile #(.NREGS(NREGS), .XLEN(XLEN)) u_rf (
    .clk    (clk),
    .we     (rf_we),
    .waddr  (rd),
    .wdata  (rf_wdata),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      illegal <= 1'b0;
    end else begin
      state <= nxt;
      pc    <= pc_nxt;
      if (nxt == HALT) illegal <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      FETCH:  if (bus.mem_ready) ir <= bus.mem_rdata;
      DECODE: begin a <= rs1_val; b <= rs2_val; imm <= imm_dec; tgt <= alu_y; end
      EXEC:   aluout <= exec_val;
      MEM:    if (bus.mem_ready) mdr <= bus.mem_rdata;
      default: ;
    endcase
  end

  always_comb begin
    nxt           = state;
    pc_nxt        = pc;
    retire        = 1'b0;
    rf_we         = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = pc;
    bus.mem_wdata = '0;
    case (state)
      BOOT: nxt = FETCH;
      FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) nxt = DECODE;
      end
      DECODE: begin
        if (!legal || bad_reg) nxt = HALT;
        else if (is_br)        nxt = BRANCH;
        else if (is_jal)       nxt = JUMP;
        else                   nxt = EXEC;
      end
      EXEC: nxt = exec_bad ? HALT : (is_lw || is_sw) ? MEM : WB;
      MEM: begin
        bus.mem_req   = 1'b1;
        bus.mem_addr  = aluout;
        bus.mem_we    = is_sw;
        bus.mem_wdata = is_sw ? b : '0;
        if (bus.mem_ready) begin
          if (is_sw) begin
            pc_nxt = pc4;
            retire = 1'b1;
            nxt    = FETCH;
          end else nxt = WB;
        end
      end
      WB: begin
        rf_we  = 1'b1;
        pc_nxt = is_jalr ? aluout : pc4;
        retire = 1'b1;
        nxt    = FETCH;
      end
      BRANCH: begin
        if (taken && tgt[1]) nxt = HALT;
        else begin
          pc_nxt = taken ? tgt : pc4;
          retire = 1'b1;
          nxt    = FETCH;
        end
      end
      JUMP: begin
        if (tgt[1]) nxt = HALT;
        else begin
          rf_we  = 1'b1;
          pc_nxt = tgt;
          retire = 1'b1;
          nxt    = FETCH;
        end
      end
      default: nxt = HALT;
    endcase
  end
endmodule

// File: tb/tb_mc_core.sv
// Scoreboard bench for mc_core: expected retires and memory writes are queued per program, a monitor pops them.
module tb_mc_core;
  logic clk = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  mc_if #(.XLEN(32)) bus ();
  mc_if #(.XLEN(32)) bus16 ();
  logic [31:0] pc, pc16;
  logic retire, retire16, illegal, illegal16;

  mc_core #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .srst(srst), .bus(bus), .pc(pc), .retire(retire), .illegal(illegal));

  // RV32E instance fed a constant instruction that names x20
  mc_core #(.XLEN(32), .NREGS(16), .RESET_PC(32'h0)) dut16 (
    .clk(clk), .srst(srst), .bus(bus16), .pc(pc16), .retire(retire16), .illegal(illegal16));

  typedef struct packed { logic [31:0] pc; logic [31:0] lat; } ret_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;

  ret_t exp_ret[$];
  wr_t  exp_wr[$];
  logic [31:0] mem [256];
  int checks = 0, fails = 0, wait_n = 0, cyc = 0, req16 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] i_t(input int imm, input int rs1, input logic [2:0] f3,
                                      input int rd, input logic [6:0] op);
    logic [31:0] m;
    m = imm;
    return {m[11:0], 5'(rs1), f3, 5'(rd), op};
  endfunction
  function automatic logic [31:0] r_t(input logic [6:0] f7, input int rs2, input int rs1,
                                      input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] s_t(input int imm, input int rs2, input int rs1);
    logic [31:0] m;
    m = imm;
    return {m[11:5], 5'(rs2), 5'(rs1), 3'b010, m[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_t(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
    logic [31:0] m;
    m = imm;
    return {m[12], m[10:5], 5'(rs2), 5'(rs1), f3, m[4:1], m[11], 7'h63};
  endfunction
  function automatic logic [31:0] j_t(input int imm, input int rd);
    logic [31:0] m;
    m = imm;
    return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'h6F};
  endfunction
  function automatic logic [31:0] u_t(input int imm, input int rd, input logic [6:0] op);
    logic [31:0] m;
    m = imm;
    return {m[19:0], 5'(rd), op};
  endfunction

  function automatic void exp_r(input logic [31:0] p, input int lat);
    exp_ret.push_back({p, 32'(lat)});
  endfunction
  function automatic void exp_w(input logic [31:0] ad, input logic [31:0] d);
    exp_wr.push_back({ad, d});
  endfunction

  // Memory responder plus monitor: decides ready at the negedge, checks retire 1ns later.
  initial begin : monitor
    int cnt, start;
    logic armed, stable, w0;
    logic [31:0] a0, d0;
    ret_t r;
    wr_t w;
    cnt = 0; start = 0; armed = 1'b1; stable = 1'b1;
    w0 = 1'b0; a0 = '0; d0 = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      cyc++;
      if (srst) begin
        cnt = 0; armed = 1'b1; req16 = 0;
        bus.mem_ready = 1'b0;
      end else begin
        if (bus16.mem_req) req16++;
        if (armed && bus.mem_req) begin start = cyc; armed = 1'b0; end
        if (bus.mem_req) begin
          if (cnt == 0) begin
            a0 = bus.mem_addr; w0 = bus.mem_we; d0 = bus.mem_wdata; stable = 1'b1;
          end else if (bus.mem_addr !== a0 || bus.mem_we !== w0 || bus.mem_wdata !== d0)
            stable = 1'b0;
          if (cnt == wait_n) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = mem[bus.mem_addr[9:2]];
            if (wait_n > 0) chk("req_stable", 32'(stable), 32'd1);
            if (bus.mem_we) begin
              if (exp_wr.size() == 0) begin
                checks++; fails++;
                $display("FAIL write_unexpected actual=%h:%h required=none", bus.mem_addr, bus.mem_wdata);
              end else begin
                w = exp_wr.pop_front();
                chk("write_addr", bus.mem_addr, w.addr);
                chk("write_data", bus.mem_wdata, w.data);
              end
              mem[bus.mem_addr[9:2]] = bus.mem_wdata;
            end
            cnt = 0;
          end else begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = 32'hDEADBEEF;
            cnt++;
          end
        end else begin
          bus.mem_ready = 1'b0;
          cnt = 0;
        end
        #1;
        if (retire) begin
          if (exp_ret.size() == 0) begin
            checks++; fails++;
            $display("FAIL retire_unexpected actual=%h required=none", pc);
          end else begin
            r = exp_ret.pop_front();
            chk("retire_pc", pc, r.pc);
            chk("retire_cycles", 32'(cyc - start + 1), r.lat);
          end
          armed = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic settle();
    @(negedge clk);
    #3;
  endtask

  task automatic begin_scn(input int wn);
    srst = 1'b1;
    tick(); tick();
    settle();
    chk("rst_ctrl", {28'b0, bus.mem_req, bus.mem_we, retire, illegal}, 32'h0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_pc", pc, 32'h0);
    exp_ret.delete();
    exp_wr.delete();
    for (int i = 0; i < 256; i++) mem[i] = '0;
    wait_n = wn;
  endtask

  task automatic go(input int ncyc, input logic [31:0] epc);
    tick();
    srst = 1'b0;
    repeat (ncyc) tick();
    settle();
    chk("halt_illegal", 32'(illegal), 32'd1);
    chk("halt_pc", pc, epc);
    chk("retires_left", 32'(exp_ret.size()), 32'd0);
    chk("writes_left", 32'(exp_wr.size()), 32'd0);
  endtask

  initial begin : stim
    int n;
    bus16.mem_ready = 1'b1;
    bus16.mem_rdata = i_t(1, 0, 3'b000, 20, 7'h13);

    // addi/addi/add at zero wait: 4 cycles each, x3 = 2; all-zero word at 0x10 halts
    begin_scn(0);
    mem[0] = i_t(5, 0, 3'b000, 1, 7'h13);
    mem[1] = i_t(-3, 0, 3'b000, 2, 7'h13);
    mem[2] = r_t(7'h00, 2, 1, 3'b000, 3);
    mem[3] = s_t(64, 3, 0);
    exp_r(32'h00, 4); exp_r(32'h04, 4); exp_r(32'h08, 4); exp_r(32'h0C, 4);
    exp_w(32'h40, 32'd2);
    go(40, 32'h10);
    chk("rv32e_req_count", 32'(req16), 32'd1);
    chk("rv32e_illegal", 32'(illegal16), 32'd1);
    chk("rv32e_pc", pc16, 32'h0);

    // ALU coverage, results stored to 0x80..0xA0
    begin_scn(0);
    mem[0]  = i_t(5, 0, 3'b000, 1, 7'h13);
    mem[1]  = i_t(-3, 0, 3'b000, 2, 7'h13);
    mem[2]  = r_t(7'h20, 2, 1, 3'b000, 3);
    mem[3]  = r_t(7'h00, 2, 1, 3'b111, 4);
    mem[4]  = r_t(7'h00, 2, 1, 3'b110, 5);
    mem[5]  = r_t(7'h00, 1, 2, 3'b010, 6);
    mem[6]  = i_t(-2, 2, 3'b010, 7, 7'h13);
    mem[7]  = i_t(240, 2, 3'b111, 8, 7'h13);
    mem[8]  = i_t(256, 1, 3'b110, 9, 7'h13);
    mem[9]  = u_t(32'h12345, 10, 7'h37);
    mem[10] = u_t(1, 11, 7'h17);
    for (int k = 3; k <= 11; k++) mem[8 + k] = s_t(128 + 4 * (k - 3), k, 0);
    for (int i = 0; i < 20; i++) exp_r(32'(4 * i), 4);
    exp_w(32'h80, 32'd8);        exp_w(32'h84, 32'd5);
    exp_w(32'h88, 32'hFFFFFFFD); exp_w(32'h8C, 32'd1);
    exp_w(32'h90, 32'd1);        exp_w(32'h94, 32'h000000F0);
    exp_w(32'h98, 32'h00000105); exp_w(32'h9C, 32'h12345000);
    exp_w(32'hA0, 32'h00001028);
    go(100, 32'h50);

    // Three wait cycles on every request; sw = 4 + 2*3, lw = 5 + 2*3
    begin_scn(3);
    mem[0]  = i_t(5, 0, 3'b000, 1, 7'h13);
    mem[1]  = j_t(32, 0);
    mem[9]  = s_t(8, 1, 0);
    mem[10] = i_t(8, 0, 3'b010, 4, 7'h03);
    mem[11] = s_t(64, 4, 0);
    exp_r(32'h00, 7); exp_r(32'h04, 6); exp_r(32'h24, 10); exp_r(32'h28, 11); exp_r(32'h2C, 10);
    exp_w(32'h08, 32'd5); exp_w(32'h40, 32'd5);
    go(80, 32'h30);

    // Branches and jumps; misaligned jalr target halts and leaves x5 alone
    begin_scn(0);
    mem[0]  = j_t(16, 0);
    mem[4]  = b_t(-8, 0, 0, 3'b000);
    mem[2]  = b_t(8, 0, 0, 3'b001);
    mem[3]  = j_t(20, 0);
    mem[8]  = j_t(16, 1);
    mem[12] = s_t(128, 1, 0);
    mem[13] = i_t(256, 0, 3'b000, 1, 7'h13);
    mem[14] = i_t(7, 0, 3'b000, 5, 7'h13);
    mem[15] = i_t(3, 1, 3'b000, 5, 7'h67);
    exp_r(32'h00, 3); exp_r(32'h10, 3); exp_r(32'h08, 3); exp_r(32'h0C, 3);
    exp_r(32'h20, 3); exp_r(32'h30, 4); exp_r(32'h34, 4); exp_r(32'h38, 4);
    exp_w(32'h80, 32'h24);
    go(60, 32'h3C);
    chk("jalr_x5_kept", dut.u_rf.regs[5], 32'd7);

    // Misaligned load address halts in EXEC
    begin_scn(0);
    mem[0] = i_t(6, 0, 3'b010, 1, 7'h03);
    go(20, 32'h0);

    // Reset during the MEM wait of a store: request drops, no write, refetch from RESET_PC
    begin_scn(3);
    mem[0] = s_t(64, 0, 0);
    tick();
    srst = 1'b0;
    n = 0;
    settle();
    while (!(bus.mem_req && bus.mem_we) && n < 50) begin settle(); n++; end
    chk("reach_mem", {30'b0, bus.mem_req, bus.mem_we}, 32'd3);
    srst = 1'b1;
    settle();
    chk("srst_req_drop", 32'(bus.mem_req), 32'd0);
    chk("srst_pc", pc, 32'h0);
    srst = 1'b0;
    settle();
    chk("refetch", {bus.mem_addr[29:0], bus.mem_req, bus.mem_we}, 32'd2);
    chk("no_write", mem[16], 32'h0);
    srst = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
